// File: rtl/approx_mul_acc_if.sv
// Valid/ready stream bundle between the product source, the approx_mul_acc
// grouping accumulator and its result consumer.
interface approx_mul_acc_if #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 9
);
  logic [15:0]      in_prod;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ovf;
  logic             out_len_err;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_prod, in_valid, in_last, out_ready,
    input  in_ready, out_sum, out_cnt, out_ovf, out_len_err, out_valid
  );

  modport slave (
    input  in_prod, in_valid, in_last, out_ready,
    output in_ready, out_sum, out_cnt, out_ovf, out_len_err, out_valid
  );
endinterface

// File: rtl/approx_mul_acc.sv
// Groups a stream of 16-bit approximate-multiplier products into sums.
// Optional macro APPROX_ACC_SATURATE_EN clamps the accumulator on overflow.
module approx_mul_acc #(
  parameter int ACC_W   = 24,
  parameter int MAX_LEN = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  approx_mul_acc_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_LEN) + 1;

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W-1:0] out_sum_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic             out_ovf_q;
  logic             out_len_err_q;
  logic             out_valid_q;

  logic             in_ready;
  logic             accept;
  logic             closing;
  logic [ACC_W-1:0] acc_base;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W:0]   sum_ext;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_base;
  logic             ovf_next;
  logic             carry;

  // The output stage can always take a new result if it is empty or being drained.
  assign in_ready = !out_valid_q | bus.out_ready;
  assign accept   = bus.in_valid & in_ready;

  // A first beat starts from a clean accumulator, so IDLE contributes zero.
  always_comb begin
    acc_base = (state == ACCUM) ? acc : '0;
    ovf_base = (state == ACCUM) & ovf;
    cnt_next = (state == ACCUM) ? cnt + CNT_W'(1) : CNT_W'(1);
    sum_ext  = {1'b0, acc_base} + {{(ACC_W + 1 - 16){1'b0}}, bus.in_prod};
    carry    = sum_ext[ACC_W];
    ovf_next = ovf_base | carry;
`ifdef APPROX_ACC_SATURATE_EN
    acc_next = carry ? '1 : sum_ext[ACC_W-1:0];
`else
    acc_next = sum_ext[ACC_W-1:0];
`endif
    closing  = accept & (bus.in_last | (cnt_next == CNT_W'(MAX_LEN)));
  end

  // Group state and output hold stage; a closing beat overwrites a result being drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      out_sum_q     <= '0;
      out_cnt_q     <= '0;
      out_ovf_q     <= 1'b0;
      out_len_err_q <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      if (closing) begin
        out_valid_q   <= 1'b1;
        out_sum_q     <= acc_next;
        out_cnt_q     <= cnt_next;
        out_ovf_q     <= ovf_next;
        out_len_err_q <= !bus.in_last;
      end else if (out_valid_q & bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (accept) begin
        if (closing) begin
          state <= IDLE;
          acc   <= '0;
          cnt   <= '0;
          ovf   <= 1'b0;
        end else begin
          state <= ACCUM;
          acc   <= acc_next;
          cnt   <= cnt_next;
          ovf   <= ovf_next;
        end
      end
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_sum     = out_sum_q;
  assign bus.out_cnt     = out_cnt_q;
  assign bus.out_ovf     = out_ovf_q;
  assign bus.out_len_err = out_len_err_q;
  assign bus.out_valid   = out_valid_q;
endmodule

// File: tb/tb_approx_mul_acc.sv
// Directed bench for approx_mul_acc: default, ACC_W=17 and MAX_LEN=4 instances.
module tb_approx_mul_acc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  approx_mul_acc_if #(.ACC_W(24), .CNT_W(9)) ifa ();
  approx_mul_acc_if #(.ACC_W(17), .CNT_W(9)) ifb ();
  approx_mul_acc_if #(.ACC_W(24), .CNT_W(3)) ifc ();

  approx_mul_acc #(.ACC_W(24), .MAX_LEN(256)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  approx_mul_acc #(.ACC_W(17), .MAX_LEN(256)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  approx_mul_acc #(.ACC_W(24), .MAX_LEN(4))   dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    ifa.in_valid = 0; ifa.in_last = 0; ifa.in_prod = 0; ifa.out_ready = 1;
    ifb.in_valid = 0; ifb.in_last = 0; ifb.in_prod = 0; ifb.out_ready = 1;
    ifc.in_valid = 0; ifc.in_last = 0; ifc.in_prod = 0; ifc.out_ready = 1;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got=%0d want=0", ifa.out_valid); end
    total++; if (ifa.out_sum !== 24'd0) begin bad++; $display("[TB] FAIL rst_sum got=%0d want=0", ifa.out_sum); end
    total++; if (ifa.out_cnt !== 9'd0) begin bad++; $display("[TB] FAIL rst_cnt got=%0d want=0", ifa.out_cnt); end
    total++; if ({ifa.out_ovf, ifa.out_len_err} !== 2'b00) begin bad++; $display("[TB] FAIL rst_flags got=%b want=00", {ifa.out_ovf, ifa.out_len_err}); end
    total++; if (ifa.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_ready got=%0d want=1", ifa.in_ready); end
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic_group;
    ifa.out_ready = 1;
    ifa.in_valid = 1; ifa.in_last = 0;
    ifa.in_prod = 16'd100; tick();
    ifa.in_prod = 16'd200; tick();
    ifa.in_prod = 16'd300; tick();
    total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_early_valid got=%0d want=0", ifa.out_valid); end
    ifa.in_prod = 16'd400; ifa.in_last = 1; tick();
    ifa.in_valid = 0; ifa.in_last = 0;
    total++; if (ifa.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL basic_valid got=%0d want=1", ifa.out_valid); end
    total++; if (ifa.out_sum !== 24'd1000) begin bad++; $display("[TB] FAIL basic_sum got=%0d want=1000", ifa.out_sum); end
    total++; if (ifa.out_cnt !== 9'd4) begin bad++; $display("[TB] FAIL basic_cnt got=%0d want=4", ifa.out_cnt); end
    total++; if ({ifa.out_ovf, ifa.out_len_err} !== 2'b00) begin bad++; $display("[TB] FAIL basic_flags got=%b want=00", {ifa.out_ovf, ifa.out_len_err}); end
    tick();
    total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL basic_drain got=%0d want=0", ifa.out_valid); end
  endtask

  task automatic test_back_to_back;
    ifa.out_ready = 1;
    ifa.in_valid = 1; ifa.in_prod = 16'hFFFF; ifa.in_last = 1; tick();
    total++; if (ifa.out_sum !== 24'd65535 || ifa.out_cnt !== 9'd1 || ifa.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL single got sum=%0d cnt=%0d v=%0d want sum=65535 cnt=1 v=1", ifa.out_sum, ifa.out_cnt, ifa.out_valid); end
    ifa.in_prod = 16'd7; ifa.in_last = 0;
    total++; if (ifa.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready got=%0d want=1", ifa.in_ready); end
    tick();
    ifa.in_prod = 16'd8; ifa.in_last = 1; tick();
    total++; if (ifa.out_sum !== 24'd15 || ifa.out_cnt !== 9'd2 || ifa.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_sum got sum=%0d cnt=%0d v=%0d want sum=15 cnt=2 v=1", ifa.out_sum, ifa.out_cnt, ifa.out_valid); end
    ifa.in_prod = 16'd20; ifa.in_last = 1; tick();
    ifa.in_valid = 0; ifa.in_last = 0;
    total++; if (ifa.out_sum !== 24'd20 || ifa.out_cnt !== 9'd1 || ifa.out_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_replace got sum=%0d cnt=%0d v=%0d want sum=20 cnt=1 v=1", ifa.out_sum, ifa.out_cnt, ifa.out_valid); end
    tick();
  endtask

  task automatic test_backpressure;
    ifa.out_ready = 1;
    ifa.in_valid = 1; ifa.in_last = 0; ifa.in_prod = 16'd5; tick();
    ifa.in_prod = 16'd6; ifa.in_last = 1; tick();
    ifa.out_ready = 0; ifa.in_prod = 16'd9; ifa.in_last = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (ifa.in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_ready[%0d] got=%0d want=0", i, ifa.in_ready); end
      total++; if (ifa.out_valid !== 1'b1 || ifa.out_sum !== 24'd11 || ifa.out_cnt !== 9'd2) begin bad++; $display("[TB] FAIL bp_hold[%0d] got v=%0d sum=%0d cnt=%0d want v=1 sum=11 cnt=2", i, ifa.out_valid, ifa.out_sum, ifa.out_cnt); end
      tick();
    end
    ifa.out_ready = 1;
    #1;
    total++; if (ifa.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release_ready got=%0d want=1", ifa.in_ready); end
    tick();
    total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drained got=%0d want=0", ifa.out_valid); end
    ifa.in_prod = 16'd1; ifa.in_last = 1; tick();
    ifa.in_valid = 0; ifa.in_last = 0;
    total++; if (ifa.out_sum !== 24'd10 || ifa.out_cnt !== 9'd2) begin bad++; $display("[TB] FAIL bp_next got sum=%0d cnt=%0d want sum=10 cnt=2", ifa.out_sum, ifa.out_cnt); end
    tick();
  endtask

  task automatic test_overflow;
    logic [16:0] want_sum;
`ifdef APPROX_ACC_SATURATE_EN
    want_sum = 17'h1FFFF;
`else
    want_sum = 17'h0FFFD;
`endif
    ifb.out_ready = 1;
    ifb.in_valid = 1; ifb.in_last = 0; ifb.in_prod = 16'hFFFF; tick();
    tick();
    ifb.in_last = 1; tick();
    total++; if (ifb.out_sum !== want_sum) begin bad++; $display("[TB] FAIL ovf_sum got=%h want=%h", ifb.out_sum, want_sum); end
    total++; if (ifb.out_ovf !== 1'b1 || ifb.out_cnt !== 9'd3) begin bad++; $display("[TB] FAIL ovf_flag got ovf=%0d cnt=%0d want ovf=1 cnt=3", ifb.out_ovf, ifb.out_cnt); end
    ifb.in_prod = 16'd1; tick();
    ifb.in_valid = 0; ifb.in_last = 0;
    total++; if (ifb.out_ovf !== 1'b0 || ifb.out_sum !== 17'd1) begin bad++; $display("[TB] FAIL ovf_clear got ovf=%0d sum=%0d want ovf=0 sum=1", ifb.out_ovf, ifb.out_sum); end
    tick();
  endtask

  task automatic test_max_len;
    ifc.out_ready = 1;
    ifc.in_valid = 1; ifc.in_last = 0;
    for (int i = 1; i <= 4; i++) begin
      ifc.in_prod = 16'(i);
      tick();
    end
    total++; if (ifc.out_valid !== 1'b1 || ifc.out_sum !== 24'd10 || ifc.out_cnt !== 3'd4) begin bad++; $display("[TB] FAIL len_sum got v=%0d sum=%0d cnt=%0d want v=1 sum=10 cnt=4", ifc.out_valid, ifc.out_sum, ifc.out_cnt); end
    total++; if (ifc.out_len_err !== 1'b1) begin bad++; $display("[TB] FAIL len_err got=%0d want=1", ifc.out_len_err); end
    ifc.in_prod = 16'd5; ifc.in_last = 1; tick();
    ifc.in_valid = 0; ifc.in_last = 0;
    total++; if (ifc.out_sum !== 24'd5 || ifc.out_cnt !== 3'd1 || ifc.out_len_err !== 1'b0) begin bad++; $display("[TB] FAIL len_next got sum=%0d cnt=%0d err=%0d want sum=5 cnt=1 err=0", ifc.out_sum, ifc.out_cnt, ifc.out_len_err); end
    tick();
  endtask

  task automatic test_reset_midgroup;
    ifa.out_ready = 1;
    ifa.in_valid = 1; ifa.in_last = 0;
    ifa.in_prod = 16'd50; tick();
    ifa.in_prod = 16'd60; tick();
    ifa.in_valid = 0;
    #2 rst_n = 0;
    #1;
    total++; if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1) begin bad++; $display("[TB] FAIL midrst got v=%0d rdy=%0d want v=0 rdy=1", ifa.out_valid, ifa.in_ready); end
    @(negedge clk);
    rst_n = 1;
    tick();
    total++; if (ifa.out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_noout got=%0d want=0", ifa.out_valid); end
    ifa.in_valid = 1; ifa.in_prod = 16'd5; ifa.in_last = 1; tick();
    ifa.in_valid = 0; ifa.in_last = 0;
    total++; if (ifa.out_valid !== 1'b1 || ifa.out_sum !== 24'd5 || ifa.out_cnt !== 9'd1) begin bad++; $display("[TB] FAIL midrst_next got v=%0d sum=%0d cnt=%0d want v=1 sum=5 cnt=1", ifa.out_valid, ifa.out_sum, ifa.out_cnt); end
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout got=running want=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_basic_group();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_max_len();
    test_reset_midgroup();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
